// File: rtl/wb_sram_slave_pkg.sv
// Shared types and constants for the Wishbone classic SRAM slave.
// Holds the transfer FSM state type and the wait-state counter helper.
package wb_sram_slave_pkg;

    localparam int WB_DATA_WIDTH   = 64;
    localparam int WB_ADDR_WIDTH   = 64;
    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_W           = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    // Counter preload so that exactly ws cycles are spent in WAIT (clamped to the legal range).
    function automatic logic [CNT_W-1:0] wait_load(input int ws);
        logic [CNT_W-1:0] load;
        if (ws <= 0) begin
            load = {CNT_W{1'b0}};
        end else if (ws > MAX_WAIT_STATES) begin
            load = CNT_W'(MAX_WAIT_STATES - 1);
        end else begin
            load = CNT_W'(ws - 1);
        end
        return load;
    endfunction

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave servicing an address window from a single-port synchronous SRAM.
// One SRAM access per bus cycle after a programmable number of wait states, single-cycle ack.
module wb_sram_slave
    import wb_sram_slave_pkg::*;
#(
    parameter int                DATA_W      = WB_DATA_WIDTH,
    parameter int                ADDR_W      = WB_ADDR_WIDTH,
    parameter int                MEM_AW      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h0,
    parameter int                WAIT_STATES = 1
) (
    input  logic                sys_clock_i,
    input  logic                sys_reset_i,
    input  logic                wbs_cycle_i,
    input  logic                wbs_strobe_i,
    input  logic                wbs_we_i,
    input  logic [ADDR_W-1:0]   wbs_addr_i,
    input  logic [DATA_W-1:0]   wbs_data_i,
    input  logic [DATA_W/8-1:0] wbs_sel_i,
    output logic                wbs_ack_o,
    output logic [DATA_W-1:0]   wbs_data_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [MEM_AW-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int               TAG_LSB   = MEM_AW + 3;
    localparam bit               HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_STATES);

    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             we_r;
    logic             hit_s;
    logic             unused_ok_s;

    // Window decode; byte offset within the 64-bit word plays no part.
    assign hit_s = wbs_cycle_i & wbs_strobe_i &
                   (wbs_addr_i[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);

    assign unused_ok_s = &{1'b0, wbs_addr_i[2:0]};

    // Transfer FSM; all bus and SRAM strobes are registered alongside the state.
    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= {CNT_W{1'b0}};
            we_r        <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_data_o  <= {DATA_W{1'b0}};
            mem_ce_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= {(DATA_W/8){1'b0}};
            mem_addr_o  <= {MEM_AW{1'b0}};
            mem_wdata_o <= {DATA_W{1'b0}};
        end else begin
            wbs_ack_o <= 1'b0;
            mem_ce_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hit_s) begin
                        we_r        <= wbs_we_i;
                        mem_addr_o  <= wbs_addr_i[TAG_LSB-1:3];
                        mem_wdata_o <= wbs_data_i;
                        mem_be_o    <= wbs_sel_i;
                        if (HAS_WAIT) begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_LOAD;
                        end else begin
                            state_r  <= ST_ACCESS;
                            mem_ce_o <= 1'b1;
                            mem_we_o <= wbs_we_i;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!wbs_cycle_i) begin
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= {CNT_W{1'b0}};
                    end else if (wait_cnt_r == {CNT_W{1'b0}}) begin
                        state_r  <= ST_ACCESS;
                        mem_ce_o <= 1'b1;
                        mem_we_o <= we_r;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ACCESS: begin
                    // A write issued here stands even if the master aborts now.
                    if (!wbs_cycle_i) begin
                        state_r <= ST_IDLE;
                    end else if (we_r) begin
                        state_r   <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                    end else begin
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!wbs_cycle_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        wbs_data_o <= mem_rdata_i;
                        state_r    <= ST_ACK;
                        wbs_ack_o  <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: three instances (1, 3 and 0 wait states) each with an SRAM model.
// Stimulus pushes expected SRAM accesses and acks; a negedge monitor pops and compares them.
module tb_wb_sram_slave;

    typedef struct {
        int          inst;
        int          cyc;
        logic [63:0] data;
    } ack_t;

    typedef struct {
        int          inst;
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } ce_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [63:0] adr   [3];
    logic [63:0] dw    [3];
    logic [7:0]  sel   [3];
    logic        ack   [3];
    logic [63:0] dr    [3];
    logic        ce    [3];
    logic        mwe   [3];
    logic [7:0]  be    [3];
    logic [15:0] maddr [3];
    logic [63:0] mwd   [3];
    logic [63:0] mrd   [3];
    logic [63:0] mem   [3][256];

    int   cyc_n    = 0;
    int   checks   = 0;
    int   failures = 0;
    int   ce_seen  [3];
    int   ack_seen [3];
    ack_t ack_q [$];
    ce_t  ce_q  [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_sram_slave #(
            .DATA_W      (64),
            .ADDR_W      (64),
            .MEM_AW      (16),
            .BASE_ADDR   (64'h0),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .sys_clock_i  (clk),
            .sys_reset_i  (rst),
            .wbs_cycle_i  (cyc[g]),
            .wbs_strobe_i (stb[g]),
            .wbs_we_i     (we[g]),
            .wbs_addr_i   (adr[g]),
            .wbs_data_i   (dw[g]),
            .wbs_sel_i    (sel[g]),
            .wbs_ack_o    (ack[g]),
            .wbs_data_o   (dr[g]),
            .mem_ce_o     (ce[g]),
            .mem_we_o     (mwe[g]),
            .mem_be_o     (be[g]),
            .mem_addr_o   (maddr[g]),
            .mem_wdata_o  (mwd[g]),
            .mem_rdata_i  (mrd[g])
        );
    end

    // SRAM models: word j of instance i resets to {C0DE,i,j,5A5A,i,j}; read data one cycle after access.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                for (int j = 0; j < 256; j++) begin
                    mem[i][j] <= {16'hC0DE, 8'(i), 8'(j), 16'h5A5A, 8'(i), 8'(j)};
                end
                mrd[i] <= 64'h0;
            end else if (ce[i]) begin
                if (mwe[i]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (be[i][b]) mem[i][maddr[i][7:0]][b*8 +: 8] <= mwd[i][b*8 +: 8];
                    end
                end else begin
                    mrd[i] <= mem[i][maddr[i][7:0]];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic unexpected(input string nm, input int i);
        checks++;
        failures++;
        $display("FAIL %s[%0d]: got event expected none (cycle %0d)", nm, i, cyc_n);
    endtask

    // Monitor: every SRAM access and every ack must match the head of its queue.
    always @(negedge clk) begin
        ce_t  ce_e;
        ack_t ack_e;
        for (int i = 0; i < 3; i++) begin
            if (ce[i] === 1'b1) begin
                ce_seen[i]++;
                if (ce_q.size() == 0) begin
                    unexpected("ce", i);
                end else begin
                    ce_e = ce_q.pop_front();
                    chk($sformatf("ce_inst[%0d]", i), 64'(i), 64'(ce_e.inst));
                    chk($sformatf("ce_cycle[%0d]", i), 64'(cyc_n), 64'(ce_e.cyc));
                    chk($sformatf("ce_we[%0d]", i), 64'(mwe[i]), 64'(ce_e.we));
                    chk($sformatf("ce_addr[%0d]", i), 64'(maddr[i]), 64'(ce_e.addr));
                    chk($sformatf("ce_be[%0d]", i), 64'(be[i]), 64'(ce_e.be));
                    chk($sformatf("ce_wdata[%0d]", i), mwd[i], ce_e.wdata);
                end
            end
            if (ack[i] === 1'b1) begin
                ack_seen[i]++;
                if (ack_q.size() == 0) begin
                    unexpected("ack", i);
                end else begin
                    ack_e = ack_q.pop_front();
                    chk($sformatf("ack_inst[%0d]", i), 64'(i), 64'(ack_e.inst));
                    chk($sformatf("ack_cycle[%0d]", i), 64'(cyc_n), 64'(ack_e.cyc));
                    chk($sformatf("ack_data[%0d]", i), dr[i], ack_e.data);
                end
            end
        end
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    // One Wishbone transfer issued at the current cycle; expectations pushed before it runs.
    task automatic xfer(input int i, input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [63:0] exp_data);
        int t;
        bit got;
        ce_t  ce_e;
        ack_t ack_e;
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; dw[i] = w ? d : 64'h0; sel[i] = s;
        t = cyc_n;
        ce_e  = '{inst: i, cyc: t + 1 + ws_of(i), we: w, addr: a[18:3], be: s, wdata: (w ? d : 64'h0)};
        ack_e = '{inst: i, cyc: t + (w ? 2 : 3) + ws_of(i), data: exp_data};
        ce_q.push_back(ce_e);
        ack_q.push_back(ack_e);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack[i] === 1'b1) got = 1'b1;
        end
        if (!got) unexpected("ack_timeout", i);
        @(posedge clk); #1;
        cyc[i] = 1'b0; stb[i] = 1'b0;
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk($sformatf("%s_ctl[%0d]", tag, i), {34'h0, ack[i], ce[i], mwe[i], be[i], maddr[i]}, 64'h0);
        chk($sformatf("%s_rdata[%0d]", tag, i), dr[i], 64'h0);
        chk($sformatf("%s_wdata[%0d]", tag, i), mwd[i], 64'h0);
    endtask

    initial begin
        int n_ce;
        int n_ack;
        int t;
        ce_t ce_e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = 64'h0; dw[i] = 64'h0; sel[i] = 8'h0;
            ce_seen[i] = 0; ack_seen[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_zero(i, "reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // One wait state: writes, reads, partial write, sel=0 write.
        xfer(0, 1'b1, 64'h40, 64'h1122334455667788, 8'hFF, 64'h0);
        xfer(0, 1'b0, 64'h40, 64'h0, 8'hFF, 64'h1122334455667788);
        xfer(0, 1'b1, 64'h47, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h1122334455667788);
        xfer(0, 1'b0, 64'h40, 64'h0, 8'h01, 64'h11223344AAAAAAAA);
        xfer(0, 1'b1, 64'h48, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h11223344AAAAAAAA);
        xfer(0, 1'b0, 64'h48, 64'h0, 8'hFF, 64'hC0DE00095A5A0009);

        // Out-of-window accesses held for 20 cycles.
        n_ce = ce_seen[0]; n_ack = ack_seen[0];
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 64'h80000; sel[0] = 8'hFF;
        repeat (20) @(posedge clk);
        #1; adr[0] = 64'h8000000000000040;
        repeat (10) @(posedge clk);
        #1; cyc[0] = 1'b0; stb[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("miss_ce", 64'(ce_seen[0]), 64'(n_ce));
        chk("miss_ack", 64'(ack_seen[0]), 64'(n_ack));

        // Three wait states: drop cycle in the second WAIT cycle of a write.
        n_ce = ce_seen[1]; n_ack = ack_seen[1];
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 64'h40;
        dw[1] = 64'h0123456789ABCDEF; sel[1] = 8'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_ce", 64'(ce_seen[1]), 64'(n_ce));
        chk("abort_ack", 64'(ack_seen[1]), 64'(n_ack));
        xfer(1, 1'b0, 64'h40, 64'h0, 8'hFF, 64'hC0DE01085A5A0108);

        // Zero wait states: a read, then reset during CAPTURE of the next read.
        xfer(2, 1'b0, 64'h80, 64'h0, 8'hF0, 64'hC0DE02105A5A0210);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 64'h88; dw[2] = 64'h0; sel[2] = 8'h3C;
        t = cyc_n;
        ce_e = '{inst: 2, cyc: t + 1, we: 1'b0, addr: 16'h0011, be: 8'h3C, wdata: 64'h0};
        ce_q.push_back(ce_e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk);
        chk_zero(2, "midreset");
        @(posedge clk); #1;
        xfer(2, 1'b0, 64'h80, 64'h0, 8'hFF, 64'hC0DE02105A5A0210);

        repeat (5) @(posedge clk);
        #1;
        chk("ack_q_left", 64'(ack_q.size()), 64'h0);
        chk("ce_q_left", 64'(ce_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
